// File: rtl/exe_stage_hs.sv
// Execute-stage output register with valid/ready handshake, result select, DIV/REM sequencing and store alignment.
// Single-cycle ops land in m_* one cycle after accept; multi-cycle ops accept in MC_DONE after the unit drops busy.
module exe_stage_hs #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_OP_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      e_valid_i,
    output logic                      e_ready_o,
    input  logic [DATA_WIDTH-1:0]     e_alu_result_i,
    input  logic                      e_mc_op_i,
    output logic                      mc_start_o,
    input  logic                      mc_busy_i,
    input  logic [DATA_WIDTH-1:0]     mc_result_i,
    output logic                      mc_abort_o,
    input  logic [1:0]                e_data_target_i,
    input  logic                      e_link_sel_i,
    input  logic [DATA_WIDTH-1:0]     e_pc4_i,
    input  logic [DATA_WIDTH-1:0]     e_brj_pc_i,
    input  logic [DATA_WIDTH-1:0]     e_regfile_rs2_i,
    input  logic [1:0]                e_store_size_i,
    input  logic [LOAD_OP_WIDTH-1:0]  e_load_op_i,
    input  logic                      e_data_wr_i,
    input  logic                      e_data_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] e_regfile_waddr_i,
    input  logic                      e_regfile_wr_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [REG_ADDR_WIDTH-1:0] m_regfile_waddr_o,
    output logic [DATA_WIDTH-1:0]     m_regfile_rd_o,
    output logic                      m_regfile_wr_o,
    output logic [DATA_WIDTH-1:0]     m_data_addr_o,
    output logic [DATA_WIDTH-1:0]     m_data_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   m_data_be_o,
    output logic                      m_data_wr_o,
    output logic                      m_data_rd_o,
    output logic [LOAD_OP_WIDTH-1:0]  m_load_op_o,
    output logic                      m_misaligned_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, MC_WAIT, MC_DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   held_result;

    logic                    out_free;
    logic                    accept;
    logic [OFFW-1:0]         off;
    logic [1:0]              size;
    logic                    mem_access;
    logic                    size_misaligned;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   store_word;
    logic [DATA_WIDTH-1:0]   sel_result;
    logic [DATA_WIDTH-1:0]   wb_result;
    logic [NB-1:0]           be_base;
    logic [NB-1:0]           be;

    assign out_free   = !m_valid_o || m_ready_i;
    assign e_ready_o  = !flush_i && out_free &&
                        ((state == IDLE && !e_mc_op_i) || state == MC_DONE);
    assign accept     = e_valid_i && e_ready_o;
    assign mc_start_o = !flush_i && state == IDLE && e_valid_i && e_mc_op_i;
    assign mc_abort_o = flush_i && state != IDLE;

    // Lane replication and alignment are keyed on the access size (store size or load size)
    always_comb begin
        size       = e_data_wr_i ? e_store_size_i : e_load_op_i[1:0];
        off        = e_alu_result_i[OFFW-1:0];
        mem_access = e_data_wr_i || e_data_rd_i;
        store_word = e_regfile_rs2_i;
        be_base    = '1;
        size_misaligned = 1'b0;
        case (size)
            2'd0: begin
                store_word      = {NB{e_regfile_rs2_i[7:0]}};
                be_base         = NB'(1);
            end
            2'd1: begin
                store_word      = {(NB/2){e_regfile_rs2_i[15:0]}};
                be_base         = NB'(3);
                size_misaligned = off[0];
            end
            2'd2: begin
                store_word      = {(NB/4){e_regfile_rs2_i[31:0]}};
                be_base         = NB'(15);
                size_misaligned = |off[1:0];
            end
            default: begin
                store_word      = e_regfile_rs2_i;
                be_base         = '1;
                size_misaligned = (DATA_WIDTH == 32) || (|off);
            end
        endcase
        misaligned = mem_access && size_misaligned;
        be         = (e_data_wr_i && !misaligned) ? (be_base << off) : '0;
    end

    always_comb begin
        sel_result = (state == MC_DONE) ? held_result : e_alu_result_i;
        case (e_data_target_i)
            2'd0:    wb_result = sel_result;
            2'd1:    wb_result = store_word;
            2'd2:    wb_result = '0;
            default: wb_result = e_link_sel_i ? e_pc4_i : e_brj_pc_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held_result <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (e_valid_i && e_mc_op_i)
                        state <= MC_WAIT;
                end
                MC_WAIT: begin
                    if (!mc_busy_i) begin
                        held_result <= mc_result_i;
                        state       <= MC_DONE;
                    end
                end
                MC_DONE: begin
                    if (accept)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data fields only move on accept so a stalled or drained slot keeps its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o         <= 1'b0;
            m_regfile_waddr_o <= '0;
            m_regfile_rd_o    <= '0;
            m_regfile_wr_o    <= 1'b0;
            m_data_addr_o     <= '0;
            m_data_wdata_o    <= '0;
            m_data_be_o       <= '0;
            m_data_wr_o       <= 1'b0;
            m_data_rd_o       <= 1'b0;
            m_load_op_o       <= '0;
            m_misaligned_o    <= 1'b0;
        end else if (flush_i) begin
            m_valid_o <= 1'b0;
        end else if (accept) begin
            m_valid_o         <= 1'b1;
            m_regfile_waddr_o <= e_regfile_waddr_i;
            m_regfile_rd_o    <= wb_result;
            m_regfile_wr_o    <= e_regfile_wr_i && !misaligned;
            m_data_addr_o     <= e_alu_result_i;
            m_data_wdata_o    <= store_word;
            m_data_be_o       <= be;
            m_data_wr_o       <= e_data_wr_i && !misaligned;
            m_data_rd_o       <= e_data_rd_i && !misaligned;
            m_load_op_o       <= e_load_op_i;
            m_misaligned_o    <= misaligned;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_hs.sv
// Bench for exe_stage_hs: directed vector table, back-pressure/DIV/flush sequences, randomized handshake traffic.
module tb_exe_stage_hs;

    typedef struct packed {
        logic [31:0] alu;
        logic [1:0]  tgt;
        logic        lsel;
        logic [31:0] pc4;
        logic [31:0] brj;
        logic [31:0] rs2;
        logic [1:0]  ssz;
        logic [2:0]  lop;
        logic        wr;
        logic        rd;
        logic [4:0]  waddr;
        logic        rwr;
    } in_t;

    typedef struct packed {
        logic [31:0] rd_o;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
        logic        mis;
        logic        rwr;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        e_valid_i = 1'b0;
    logic        e_ready_o;
    logic [31:0] e_alu_result_i = '0;
    logic        e_mc_op_i = 1'b0;
    logic        mc_start_o;
    logic        mc_busy_i;
    logic [31:0] mc_result_i;
    logic        mc_abort_o;
    logic [1:0]  e_data_target_i = '0;
    logic        e_link_sel_i = 1'b0;
    logic [31:0] e_pc4_i = '0;
    logic [31:0] e_brj_pc_i = '0;
    logic [31:0] e_regfile_rs2_i = '0;
    logic [1:0]  e_store_size_i = '0;
    logic [2:0]  e_load_op_i = '0;
    logic        e_data_wr_i = 1'b0;
    logic        e_data_rd_i = 1'b0;
    logic [4:0]  e_regfile_waddr_i = '0;
    logic        e_regfile_wr_i = 1'b0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [4:0]  m_regfile_waddr_o;
    logic [31:0] m_regfile_rd_o;
    logic        m_regfile_wr_o;
    logic [31:0] m_data_addr_o;
    logic [31:0] m_data_wdata_o;
    logic [3:0]  m_data_be_o;
    logic        m_data_wr_o;
    logic        m_data_rd_o;
    logic [2:0]  m_load_op_o;
    logic        m_misaligned_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_stage_hs #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_OP_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
        .e_alu_result_i(e_alu_result_i), .e_mc_op_i(e_mc_op_i),
        .mc_start_o(mc_start_o), .mc_busy_i(mc_busy_i), .mc_result_i(mc_result_i),
        .mc_abort_o(mc_abort_o),
        .e_data_target_i(e_data_target_i), .e_link_sel_i(e_link_sel_i),
        .e_pc4_i(e_pc4_i), .e_brj_pc_i(e_brj_pc_i), .e_regfile_rs2_i(e_regfile_rs2_i),
        .e_store_size_i(e_store_size_i), .e_load_op_i(e_load_op_i),
        .e_data_wr_i(e_data_wr_i), .e_data_rd_i(e_data_rd_i),
        .e_regfile_waddr_i(e_regfile_waddr_i), .e_regfile_wr_i(e_regfile_wr_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_regfile_waddr_o(m_regfile_waddr_o), .m_regfile_rd_o(m_regfile_rd_o),
        .m_regfile_wr_o(m_regfile_wr_o), .m_data_addr_o(m_data_addr_o),
        .m_data_wdata_o(m_data_wdata_o), .m_data_be_o(m_data_be_o),
        .m_data_wr_o(m_data_wr_o), .m_data_rd_o(m_data_rd_o),
        .m_load_op_o(m_load_op_o), .m_misaligned_o(m_misaligned_o)
    );

    // Behavioural multi-cycle unit: busy for mc_lat cycles starting the cycle after start
    int          mc_lat = 5;
    logic [31:0] mc_val = '0;
    int          mc_cnt;
    int          n_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt  <= 0;
            n_start <= 0;
        end else begin
            if (mc_start_o) n_start <= n_start + 1;
            if (mc_abort_o)      mc_cnt <= 0;
            else if (mc_start_o) mc_cnt <= mc_lat;
            else if (mc_cnt > 0) mc_cnt <= mc_cnt - 1;
        end
    end

    assign mc_busy_i   = (mc_cnt != 0);
    assign mc_result_i = mc_busy_i ? 32'hBAD0BAD0 : mc_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        e_alu_result_i    = v.alu;
        e_data_target_i   = v.tgt;
        e_link_sel_i      = v.lsel;
        e_pc4_i           = v.pc4;
        e_brj_pc_i        = v.brj;
        e_regfile_rs2_i   = v.rs2;
        e_store_size_i    = v.ssz;
        e_load_op_i       = v.lop;
        e_data_wr_i       = v.wr;
        e_data_rd_i       = v.rd;
        e_regfile_waddr_i = v.waddr;
        e_regfile_wr_i    = v.rwr;
    endtask

    function automatic in_t alu_op(input logic [31:0] alu, input logic [4:0] waddr);
        in_t v;
        v       = '0;
        v.alu   = alu;
        v.waddr = waddr;
        v.rwr   = 1'b1;
        return v;
    endfunction

    // Reference: lanes and alignment from byte counts and modular arithmetic
    function automatic exp_t ref_model(input in_t v);
        exp_t r;
        int   nbytes;
        int   off;
        logic mem;
        r      = '0;
        mem    = v.wr | v.rd;
        nbytes = 1 << (v.wr ? int'(v.ssz) : int'(v.lop[1:0]));
        off    = int'(v.alu % 4);
        r.mis  = mem && (nbytes > 4 || (off % nbytes) != 0);
        for (int k = 0; k < 4; k++) begin
            r.wdata[8*k +: 8] = v.rs2[8*(k % nbytes) +: 8];
            r.be[k]           = v.wr && !r.mis && k >= off && k < off + nbytes;
        end
        r.wr  = v.wr & !r.mis;
        r.rd  = v.rd & !r.mis;
        r.rwr = v.rwr & !r.mis;
        case (v.tgt)
            2'd0:    r.rd_o = v.alu;
            2'd1:    r.rd_o = r.wdata;
            2'd2:    r.rd_o = 32'h0;
            default: r.rd_o = v.lsel ? v.pc4 : v.brj;
        endcase
        return r;
    endfunction

    task automatic check_out(input string tag, input in_t v, input exp_t e);
        check({tag, "_rd"},    64'(m_regfile_rd_o),    64'(e.rd_o));
        check({tag, "_wdata"}, 64'(m_data_wdata_o),    64'(e.wdata));
        check({tag, "_be"},    64'(m_data_be_o),       64'(e.be));
        check({tag, "_wr"},    64'(m_data_wr_o),       64'(e.wr));
        check({tag, "_rdstb"}, 64'(m_data_rd_o),       64'(e.rd));
        check({tag, "_mis"},   64'(m_misaligned_o),    64'(e.mis));
        check({tag, "_rwr"},   64'(m_regfile_wr_o),    64'(e.rwr));
        check({tag, "_waddr"}, 64'(m_regfile_waddr_o), 64'(v.waddr));
        check({tag, "_addr"},  64'(m_data_addr_o),     64'(v.alu));
        check({tag, "_lop"},   64'(m_load_op_o),       64'(v.lop));
    endtask

    vec_t tbl[11];
    in_t  cur;
    exp_t exp_o;
    in_t  exp_in;
    logic exp_valid;
    logic exp_rdy;
    logic acc;
    logic hold;
    int   waited;
    int   r;

    initial begin
        tbl[0]  = '{'{32'h15, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 5'd3, 1'b1},
                    '{32'h15, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[1]  = '{'{32'h1002, 2'd2, 1'b0, 32'h0, 32'h0, 32'hA5, 2'd0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0},
                    '{32'h0, 32'hA5A5A5A5, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[2]  = '{'{32'h1002, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234, 2'd1, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0},
                    '{32'h0, 32'h12341234, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[3]  = '{'{32'h1001, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 2'd2, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0},
                    '{32'h0, 32'hCAFEF00D, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{'{32'h1000, 2'd2, 1'b0, 32'h0, 32'h0, 32'h01020304, 2'd3, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0},
                    '{32'h0, 32'h01020304, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{'{32'h40, 2'd3, 1'b1, 32'h104, 32'h2000, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1},
                    '{32'h104, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[6]  = '{'{32'h40, 2'd3, 1'b0, 32'h104, 32'h2000, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1},
                    '{32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[7]  = '{'{32'h1000, 2'd1, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 2'd2, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0},
                    '{32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{'{32'h1003, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd1, 1'b0, 1'b1, 5'd7, 1'b1},
                    '{32'h1003, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[9]  = '{'{32'h1004, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1, 5'd8, 1'b1},
                    '{32'h1004, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[10] = '{'{32'h1003, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd4, 1'b0, 1'b1, 5'd9, 1'b1},
                    '{32'h1003, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1}};

        // Reset state
        #12;
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_rd", 64'(m_regfile_rd_o), 64'd0);
        check("rst_be", 64'(m_data_be_o), 64'd0);
        check("rst_mc_start", 64'(mc_start_o), 64'd0);
        check("rst_mc_abort", 64'(mc_abort_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors issued back to back with m_ready held high
        m_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            e_valid_i = 1'b1;
            apply(tbl[i].i);
            #1;
            check($sformatf("tbl%0d_e_ready", i), 64'(e_ready_o), 64'd1);
            @(negedge clk);
            check($sformatf("tbl%0d_m_valid", i), 64'(m_valid_o), 64'd1);
            check_out($sformatf("tbl%0d", i), tbl[i].i, tbl[i].e);
        end
        e_valid_i = 1'b0;
        @(negedge clk);
        check("drain_m_valid", 64'(m_valid_o), 64'd0);

        // Back-pressure: slot holds A while B waits
        e_valid_i = 1'b1;
        apply(alu_op(32'h11, 5'd4));
        @(negedge clk);
        m_ready_i = 1'b0;
        apply(alu_op(32'h22, 5'd5));
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_e_ready", 64'(e_ready_o), 64'd0);
            check("bp_m_valid", 64'(m_valid_o), 64'd1);
            check("bp_rd_frozen", 64'(m_regfile_rd_o), 64'h11);
            check("bp_waddr_frozen", 64'(m_regfile_waddr_o), 64'd4);
            @(negedge clk);
        end
        m_ready_i = 1'b1;
        #1;
        check("bp_release_e_ready", 64'(e_ready_o), 64'd1);
        @(negedge clk);
        check("bp_next_rd", 64'(m_regfile_rd_o), 64'h22);
        check("bp_next_waddr", 64'(m_regfile_waddr_o), 64'd5);
        e_valid_i = 1'b0;
        @(negedge clk);

        // DIV through the multi-cycle unit, busy for 5 cycles
        mc_lat = 5;
        mc_val = 32'h7;
        e_valid_i = 1'b1;
        e_mc_op_i = 1'b1;
        apply(alu_op(32'h3C, 5'd10));
        #1;
        check("div_start", 64'(mc_start_o), 64'd1);
        check("div_e_ready_idle", 64'(e_ready_o), 64'd0);
        waited = 0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk);
            waited = w;
            if (e_ready_o) break;
        end
        check("div_wait_cycles", 64'(waited), 64'd7);
        check("div_no_early_valid", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        e_valid_i = 1'b0;
        e_mc_op_i = 1'b0;
        check("div_m_valid", 64'(m_valid_o), 64'd1);
        check("div_rd", 64'(m_regfile_rd_o), 64'h7);
        check("div_waddr", 64'(m_regfile_waddr_o), 64'd10);
        check("div_start_pulses", 64'(n_start), 64'd1);
        @(negedge clk);

        // Flush in the third MC_WAIT cycle aborts the op without writeback
        mc_val = 32'h99;
        e_valid_i = 1'b1;
        e_mc_op_i = 1'b1;
        apply(alu_op(32'h50, 5'd6));
        repeat (3) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_abort", 64'(mc_abort_o), 64'd1);
        check("flush_e_ready", 64'(e_ready_o), 64'd0);
        check("flush_no_start", 64'(mc_start_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        e_valid_i = 1'b0;
        e_mc_op_i = 1'b0;
        #1;
        check("post_flush_abort", 64'(mc_abort_o), 64'd0);
        check("post_flush_m_valid", 64'(m_valid_o), 64'd0);
        repeat (8) @(negedge clk);
        check("flush_no_writeback", 64'(m_valid_o), 64'd0);
        check("flush_rd_unchanged", 64'(m_regfile_rd_o), 64'h7);
        check("flush_start_pulses", 64'(n_start), 64'd2);
        e_valid_i = 1'b1;
        apply(alu_op(32'h77, 5'd2));
        #1;
        check("flush_back_idle", 64'(e_ready_o), 64'd1);
        @(negedge clk);
        check("flush_recover_rd", 64'(m_regfile_rd_o), 64'h77);
        e_valid_i = 1'b0;
        @(negedge clk);

        // Randomized traffic against the reference model
        exp_valid = 1'b0;
        hold = 1'b0;
        cur = '0;
        for (int it = 0; it < 400; it++) begin
            if (!hold) begin
                cur.alu   = $urandom;
                cur.tgt   = 2'($urandom_range(0, 3));
                cur.lsel  = 1'($urandom_range(0, 1));
                cur.pc4   = $urandom;
                cur.brj   = $urandom;
                cur.rs2   = $urandom;
                cur.ssz   = 2'($urandom_range(0, 3));
                cur.lop   = 3'($urandom_range(0, 7));
                r         = $urandom_range(0, 2);
                cur.wr    = (r == 1);
                cur.rd    = (r == 2);
                cur.waddr = 5'($urandom_range(0, 31));
                cur.rwr   = 1'($urandom_range(0, 1));
                e_valid_i = ($urandom_range(0, 3) != 0);
            end
            m_ready_i = ($urandom_range(0, 9) < 7);
            flush_i   = ($urandom_range(0, 15) == 0);
            apply(cur);
            #1;
            exp_rdy = !flush_i && (!exp_valid || m_ready_i);
            check("rnd_e_ready", 64'(e_ready_o), 64'(exp_rdy));
            acc = e_valid_i && exp_rdy;
            if (flush_i) begin
                exp_valid = 1'b0;
            end else if (acc) begin
                exp_valid = 1'b1;
                exp_in    = cur;
                exp_o     = ref_model(cur);
            end else if (m_ready_i) begin
                exp_valid = 1'b0;
            end
            hold = e_valid_i && !acc && !flush_i;
            @(negedge clk);
            check("rnd_m_valid", 64'(m_valid_o), 64'(exp_valid));
            if (exp_valid) check_out("rnd", exp_in, exp_o);
        end
        flush_i = 1'b0;
        e_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage_hs.md
Name: exe_stage_hs

Overview:
Parametrised execute-stage output block with a valid/ready handshake, to replace the free-running execute pipeline register.
- Selects the writeback result and sequences multi-cycle (DIV/REM) operations through an external unit.
- Aligns store data into byte lanes with byte enables and flags misaligned accesses.
- Holds its E/M pipeline register under back-pressure and clears it on flush.
- ALU and multi-cycle arithmetic stay in separate modules; this block consumes their results.

Parameters:
DATA_WIDTH, 32, datapath width; must be 32 or 64. Byte lanes NB = DATA_WIDTH/8; OFFW = log2(NB).
REG_ADDR_WIDTH, 5, register-file address width.
LOAD_OP_WIDTH, 3, load-op code width; bits [1:0] give the access size.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush
e_valid_i  in  1  upstream instruction valid
e_ready_o  out  1  instruction accepted this cycle
e_alu_result_i  in  DATA_WIDTH  single-cycle ALU result; also the memory address
e_mc_op_i  in  1  instruction needs the multi-cycle unit
mc_start_o  out  1  one-cycle start pulse to the multi-cycle unit
mc_busy_i  in  1  multi-cycle unit busy
mc_result_i  in  DATA_WIDTH  multi-cycle result
mc_abort_o  out  1  abort of an in-flight multi-cycle operation
e_data_target_i  in  2  0 result, 1 store data, 2 zero, 3 link
e_link_sel_i  in  1  link source: 1 = e_pc4_i, 0 = e_brj_pc_i
e_pc4_i  in  DATA_WIDTH  PC+4
e_brj_pc_i  in  DATA_WIDTH  branch/jump PC
e_regfile_rs2_i  in  DATA_WIDTH  store source
e_store_size_i  in  2  0 B, 1 H, 2 W, 3 D
e_load_op_i  in  LOAD_OP_WIDTH  load op
e_data_wr_i  in  1  store
e_data_rd_i  in  1  load
e_regfile_waddr_i  in  REG_ADDR_WIDTH  rd
e_regfile_wr_i  in  1  rd write enable
m_valid_o  out  1  output register valid
m_ready_i  in  1  downstream accepts
m_regfile_waddr_o, m_regfile_rd_o, m_regfile_wr_o  out  REG_ADDR_WIDTH/DATA_WIDTH/1  writeback
m_data_addr_o, m_data_wdata_o, m_data_be_o  out  DATA_WIDTH/DATA_WIDTH/NB  memory request
m_data_wr_o, m_data_rd_o  out  1/1  memory strobes
m_load_op_o  out  LOAD_OP_WIDTH  registered load op
m_misaligned_o  out  1  misaligned access flag

Behaviour:
- Reset: every registered output is 0, state is IDLE, the held result register is 0.
- Output slot: out_free = !m_valid_o | m_ready_i.
  - When the block accepts, all m_* outputs load and m_valid_o goes to 1.
  - Otherwise m_ready_i clears m_valid_o; m_* data outputs keep their values.
  - With m_valid_o & !m_ready_i, all m_* outputs stay stable.
- FSM states: IDLE, MC_WAIT, MC_DONE.
  - IDLE, e_valid_i & !e_mc_op_i: e_ready_o = out_free, combinational; single-cycle result is e_alu_result_i.
  - IDLE, e_valid_i & e_mc_op_i: mc_start_o = 1 for one cycle, e_ready_o = 0; go to MC_WAIT.
  - MC_WAIT: when mc_busy_i = 0, capture mc_result_i into the held register and go to MC_DONE. Time-out is unbounded.
  - MC_DONE: e_ready_o = out_free; on accept, result is the held value and state returns to IDLE.
- Multi-cycle unit contract: mc_busy_i rises in the cycle after mc_start_o; mc_result_i is valid in the first MC_WAIT cycle with mc_busy_i = 0.
- Upstream holds all e_* inputs stable while e_valid_i & !e_ready_o.
- Flush (priority over everything):
  - e_ready_o = 0, m_valid_o <= 0, state <= IDLE.
  - mc_abort_o = flush_i & (state != IDLE).
  - mc_start_o is suppressed in the flush cycle.
- Result mux:
  - target 0: the selected result.
  - target 1: the aligned store word.
  - target 2: 0.
  - target 3: e_pc4_i if e_link_sel_i, else e_brj_pc_i.
- Address: m_data_addr_o = e_alu_result_i; off = address[OFFW-1:0].
- Store data lanes:
  - B: rs2[7:0] replicated to all lanes.
  - H: rs2[15:0] replicated.
  - W: rs2[31:0] replicated.
  - D: rs2.
- Byte enables: B = 1<<off; H = 2'b11<<off; W = 4'hF<<off; D = all ones. Only driven for stores; otherwise 0.
- Access size: e_store_size_i for stores, e_load_op_i[1:0] for loads.
- Misaligned when any of:
  - H with off[0] set.
  - W with off[1:0] nonzero.
  - D with off nonzero.
  - D when DATA_WIDTH = 32.
- On misaligned: m_misaligned_o = 1 and m_data_wr_o, m_data_rd_o, m_data_be_o and m_regfile_wr_o are forced to 0.
- No memory access: m_misaligned_o = 0.
- Reset mid-operation: returns to IDLE; an in-flight multi-cycle result is discarded.

Test Plan:
- Single-cycle ADD, e_alu_result_i = 0x15, waddr 3, m_ready_i = 1 -> next cycle m_valid_o = 1, m_regfile_rd_o = 0x15, m_regfile_waddr_o = 3; e_ready_o stays 1 through back-to-back issue.
- m_ready_i = 0 for 3 cycles with m_valid_o = 1 -> e_ready_o = 0 and outputs frozen; m_ready_i = 1 -> next instruction loads.
- DIV: mc_busy_i high for 5 cycles, mc_result_i = 0x7 -> exactly one mc_start_o pulse, e_ready_o = 0 throughout; accepted in MC_DONE with m_regfile_rd_o = 0x7.
- flush_i in the third MC_WAIT cycle -> mc_abort_o = 1, state IDLE, m_valid_o = 0; no writeback of the aborted op.
- SB rs2 = 0xA5, addr 0x1002 -> m_data_be_o = 4'b0100, m_data_wdata_o = 0xA5A5A5A5. SH at 0x1002 -> be 4'b1100.
- SW at 0x1001 -> m_misaligned_o = 1, m_data_wr_o = 0, m_data_be_o = 0. Size code 3 with DATA_WIDTH = 32 -> misaligned.
